// File: rtl/addr_capture_pkg.sv
// Shared definitions for the address-capture front end of the seven-segment monitor.
package addr_capture_pkg;

    localparam int ADDR_W = 21;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ARMED  = 2'd1,
        ST_FROZEN = 2'd2,
        ST_STEP   = 2'd3
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter, and a one-cycle pulse
// on each accepted rising level.
module btn_debounce #(
    parameter int DEB_CYCLES = 65_536
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic level,
    output logic rise_p
);

    localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            rise_p <= 1'b0;
        end else begin
            sync1  <= din;
            sync2  <= sync1;
            rise_p <= 1'b0;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (sync2 != level) begin
                if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                    level  <= sync2;
                    cnt    <= '0;
                    rise_p <= sync2;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/addr_capture.sv
// Samples the CPU address on each memory strobe and presents a rate-limited display value,
// with freeze, single-step and an address-match trigger that freezes on a hit.
module addr_capture
    import addr_capture_pkg::*;
#(
    parameter int HOLD_CYCLES = 2_000_000,
    parameter int DEB_CYCLES  = 65_536
) (
    input  logic              clk_peripheral,
    input  logic              peripheral_resetn,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_strobe,
    input  logic              btn_freeze,
    input  logic              btn_step,
    input  logic              trig_en,
    input  logic [ADDR_W-1:0] trig_addr,
    input  logic [ADDR_W-1:0] trig_mask,
    output logic [ADDR_W-1:0] address,
    output logic              frozen,
    output logic              hit,
    output logic [1:0]        state
);

    localparam int CNT_W = $clog2(HOLD_CYCLES);

    state_t            cur_state;
    logic [CNT_W-1:0]  refresh;
    logic [ADDR_W-1:0] pending;
    logic              pend_valid;
    logic              frz_p;
    logic              stp_p;
    logic              frz_level;
    logic              stp_level;
    logic              unused_levels;
    logic              running;
    logic              tick;
    logic              match;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_freeze (
        .clk    (clk_peripheral),
        .resetn (peripheral_resetn),
        .din    (btn_freeze),
        .level  (frz_level),
        .rise_p (frz_p)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk    (clk_peripheral),
        .resetn (peripheral_resetn),
        .din    (btn_step),
        .level  (stp_level),
        .rise_p (stp_p)
    );

    assign unused_levels = frz_level ^ stp_level;

    assign running = (cur_state == ST_RUN) || (cur_state == ST_ARMED);
    assign tick    = running && (refresh == CNT_W'(HOLD_CYCLES - 1));
    assign match   = cpu_strobe && (((cpu_addr ^ trig_addr) & trig_mask) == '0);
    assign state   = cur_state;

    always_ff @(posedge clk_peripheral or negedge peripheral_resetn) begin
        if (!peripheral_resetn) begin
            refresh <= '0;
        end else if (!running || tick) begin
            refresh <= '0;
        end else begin
            refresh <= refresh + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_peripheral or negedge peripheral_resetn) begin
        if (!peripheral_resetn) begin
            cur_state  <= ST_RUN;
            address    <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
            frozen     <= 1'b0;
            hit        <= 1'b0;
        end else begin
            case (cur_state)
                ST_RUN, ST_ARMED: begin
                    // A trigger hit captures the matching address immediately, ignoring refresh phase.
                    if (cur_state == ST_ARMED && match) begin
                        address   <= cpu_addr;
                        hit       <= 1'b1;
                        frozen    <= 1'b1;
                        cur_state <= ST_FROZEN;
                    end else begin
                        if (tick) begin
                            if (cpu_strobe) begin
                                address <= cpu_addr;
                            end else if (pend_valid) begin
                                address <= pending;
                            end
                            pend_valid <= 1'b0;
                        end else if (cpu_strobe) begin
                            pending    <= cpu_addr;
                            pend_valid <= 1'b1;
                        end

                        if (cur_state == ST_RUN) begin
                            if (trig_en) begin
                                cur_state <= ST_ARMED;
                            end else if (frz_p) begin
                                frozen    <= 1'b1;
                                cur_state <= ST_FROZEN;
                            end
                        end else begin
                            if (frz_p) begin
                                frozen    <= 1'b1;
                                cur_state <= ST_FROZEN;
                            end else if (!trig_en) begin
                                cur_state <= ST_RUN;
                            end
                        end
                    end
                end

                ST_FROZEN, ST_STEP: begin
                    // Resume takes precedence over both step request and step capture.
                    if (frz_p) begin
                        cur_state  <= trig_en ? ST_ARMED : ST_RUN;
                        frozen     <= 1'b0;
                        hit        <= 1'b0;
                        pend_valid <= 1'b0;
                    end else if (cur_state == ST_FROZEN) begin
                        if (stp_p) begin
                            cur_state <= ST_STEP;
                        end
                    end else if (cpu_strobe) begin
                        address   <= cpu_addr;
                        cur_state <= ST_FROZEN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addr_capture.sv
// Bench for addr_capture: directed scenarios plus randomized traffic, checked every cycle
// against a behavioural model of display, FSM and button conditioning.
module tb_addr_capture;

    localparam int HOLD = 8;
    localparam int DEB  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [20:0] cpu_addr;
    logic        cpu_strobe;
    logic        btn_freeze;
    logic        btn_step;
    logic        trig_en;
    logic [20:0] trig_addr;
    logic [20:0] trig_mask;
    logic [20:0] address;
    logic        frozen;
    logic        hit;
    logic [1:0]  dut_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    addr_capture #(.HOLD_CYCLES(HOLD), .DEB_CYCLES(DEB)) dut (
        .clk_peripheral    (clk),
        .peripheral_resetn (rst_n),
        .cpu_addr          (cpu_addr),
        .cpu_strobe        (cpu_strobe),
        .btn_freeze        (btn_freeze),
        .btn_step          (btn_step),
        .trig_en           (trig_en),
        .trig_addr         (trig_addr),
        .trig_mask         (trig_mask),
        .address           (address),
        .frozen            (frozen),
        .hit               (hit),
        .state             (dut_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: 0=RUN 1=ARMED 2=FROZEN 3=STEP
    logic [20:0] m_addr = '0;
    logic [20:0] m_pend = '0;
    bit          m_pv = 0;
    bit          m_hit = 0;
    int          m_st = 0;
    int          m_cnt = 0;
    bit          d_s1[2];
    bit          d_s2[2];
    bit          d_lvl[2];
    bit          d_pulse[2];
    int          d_run[2];

    task automatic model_reset();
        m_addr = '0; m_pend = '0; m_pv = 0; m_hit = 0; m_st = 0; m_cnt = 0;
        for (int b = 0; b < 2; b++) begin
            d_s1[b] = 0; d_s2[b] = 0; d_lvl[b] = 0; d_pulse[b] = 0; d_run[b] = 0;
        end
    endtask

    task automatic deb_step(input int b, input bit raw);
        bit smp;
        smp = d_s2[b];
        d_s2[b] = d_s1[b];
        d_s1[b] = raw;
        d_pulse[b] = 0;
        if (smp != d_lvl[b]) begin
            d_run[b]++;
            if (d_run[b] == DEB) begin
                d_lvl[b] = smp;
                d_run[b] = 0;
                d_pulse[b] = smp;
            end
        end else begin
            d_run[b] = 0;
        end
    endtask

    task automatic model_step();
        bit frz, stp, running, tick, match;
        int nst;
        frz     = d_pulse[0];
        stp     = d_pulse[1];
        running = (m_st < 2);
        tick    = running && (m_cnt == HOLD - 1);
        match   = cpu_strobe && (((cpu_addr ^ trig_addr) & trig_mask) == 21'd0);
        nst     = m_st;
        if (running) begin
            if (m_st == 1 && match) begin
                m_addr = cpu_addr; m_hit = 1; nst = 2;
            end else begin
                if (tick) begin
                    if (cpu_strobe) m_addr = cpu_addr;
                    else if (m_pv) m_addr = m_pend;
                    m_pv = 0;
                end else if (cpu_strobe) begin
                    m_pend = cpu_addr; m_pv = 1;
                end
                if (m_st == 0) nst = trig_en ? 1 : (frz ? 2 : 0);
                else nst = frz ? 2 : (!trig_en ? 0 : 1);
            end
            m_cnt = (m_cnt + 1) % HOLD;
        end else begin
            m_cnt = 0;
            if (frz) begin
                nst = trig_en ? 1 : 0; m_hit = 0; m_pv = 0;
            end else if (m_st == 2 && stp) begin
                nst = 3;
            end else if (m_st == 3 && cpu_strobe) begin
                m_addr = cpu_addr; nst = 2;
            end
        end
        m_st = nst;
        deb_step(0, btn_freeze);
        deb_step(1, btn_step);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        chk("address", 32'(address), 32'(m_addr));
        chk("state", 32'(dut_state), 32'(m_st));
        chk("frozen", 32'(frozen), 32'(m_st >= 2));
        chk("hit", 32'(hit), 32'(m_hit));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [20:0] a);
        cpu_addr = a;
        cpu_strobe = 1'b1;
        cyc(1);
        cpu_strobe = 1'b0;
    endtask

    task automatic press_freeze();
        btn_freeze = 1'b1; cyc(10);
        btn_freeze = 1'b0; cyc(10);
    endtask

    task automatic press_step();
        btn_step = 1'b1; cyc(10);
        btn_step = 1'b0; cyc(10);
    endtask

    initial begin
        cpu_addr = '0; cpu_strobe = 1'b0; btn_freeze = 1'b0; btn_step = 1'b0;
        trig_en = 1'b0; trig_addr = 21'h14000; trig_mask = 21'h1F000;
        rst_n = 1'b0;
        cyc(3);
        chk("rst_address", 32'(address), 32'h0);
        chk("rst_state", 32'(dut_state), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // RUN: newest strobe shown after a tick, then held with no new samples
        strobe(21'h00100); strobe(21'h00200); strobe(21'h1ABCD);
        cyc(HOLD + 2);
        chk("run_newest", 32'(address), 32'h1ABCD);
        cyc(HOLD);
        chk("run_hold", 32'(address), 32'h1ABCD);

        // Debounce: short glitch ignored, long press freezes
        btn_freeze = 1'b1; cyc(2); btn_freeze = 1'b0; cyc(10);
        chk("glitch_state", 32'(dut_state), 32'd0);
        press_freeze();
        chk("frz_state", 32'(dut_state), 32'd2);
        chk("frz_frozen", 32'(frozen), 32'd1);
        strobe(21'h00777); strobe(21'h00778); cyc(HOLD + 2);
        chk("frz_addr", 32'(address), 32'h1ABCD);

        // Single step
        press_step();
        chk("step_state", 32'(dut_state), 32'd3);
        strobe(21'h05555);
        chk("step_addr", 32'(address), 32'h05555);
        chk("step_back", 32'(dut_state), 32'd2);
        strobe(21'h0AAAA); cyc(2);
        chk("step_once", 32'(address), 32'h05555);

        // Trigger
        trig_en = 1'b1;
        press_freeze();
        chk("arm_state", 32'(dut_state), 32'd1);
        strobe(21'h13FFF); cyc(HOLD + 2);
        chk("nomatch_addr", 32'(address), 32'h13FFF);
        chk("nomatch_hit", 32'(hit), 32'd0);
        strobe(21'h14123);
        chk("match_addr", 32'(address), 32'h14123);
        chk("match_hit", 32'(hit), 32'd1);
        chk("match_state", 32'(dut_state), 32'd2);
        press_freeze();
        chk("rearm_state", 32'(dut_state), 32'd1);
        chk("rearm_hit", 32'(hit), 32'd0);

        // Match and freeze pulse on the same edge
        btn_freeze = 1'b1; cyc(6);
        strobe(21'h14ABC);
        chk("coll_hit", 32'(hit), 32'd1);
        chk("coll_state", 32'(dut_state), 32'd2);
        cyc(3); btn_freeze = 1'b0; cyc(10);
        chk("coll_one_pulse", 32'(dut_state), 32'd2);

        // STEP: freeze pulse beats strobe
        press_step();
        btn_freeze = 1'b1; cyc(6);
        strobe(21'h00001);
        chk("stepcoll_state", 32'(dut_state), 32'd1);
        chk("stepcoll_addr", 32'(address), 32'h14ABC);
        cyc(3); btn_freeze = 1'b0; cyc(10);

        // Asynchronous reset mid-STEP
        trig_en = 1'b0; cyc(2);
        press_freeze();
        press_step();
        chk("pre_reset_state", 32'(dut_state), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_addr", 32'(address), 32'h0);
        chk("async_state", 32'(dut_state), 32'd0);
        chk("async_frozen", 32'(frozen), 32'd0);
        chk("async_hit", 32'(hit), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cpu_strobe = ($urandom_range(0, 2) == 0);
            cpu_addr = ($urandom_range(0, 3) == 0) ? (trig_addr ^ 21'($urandom_range(0, 255)))
                                                   : 21'($urandom);
            if ($urandom_range(0, 9) == 0) btn_freeze = ~btn_freeze;
            if ($urandom_range(0, 9) == 0) btn_step = ~btn_step;
            if ($urandom_range(0, 199) == 0) trig_en = ~trig_en;
            if ($urandom_range(0, 299) == 0) trig_mask = ($urandom_range(0, 1) == 1) ? 21'h0 : 21'($urandom);
            cyc(1);
            if (i % 1500 == 1499) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rnd_async_addr", 32'(address), 32'h0);
                @(posedge clk); #1 rst_n = 1'b1;
            end
        end
        cpu_strobe = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
